// File: rtl/register_file_dual_write.sv
// Register file with two async read ports, two sync write ports (A = ALU, B = load)
// and a per-register busy scoreboard that feeds the stall logic.
module register_file_dual_write #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  CPU_CLOCK,
  input  logic                  CLEAR,
  input  logic [ADDR_WIDTH-1:0] READ_REG_1,
  input  logic [ADDR_WIDTH-1:0] READ_REG_2,
  output logic [DATA_WIDTH-1:0] READ_DATA_1,
  output logic [DATA_WIDTH-1:0] READ_DATA_2,
  output logic                  BUSY_1,
  output logic                  BUSY_2,
  input  logic [ADDR_WIDTH-1:0] WRITE_REG_A,
  input  logic [DATA_WIDTH-1:0] WRITE_DATA_A,
  input  logic                  WRITE_ENABLE_A,
  input  logic [ADDR_WIDTH-1:0] WRITE_REG_B,
  input  logic [DATA_WIDTH-1:0] WRITE_DATA_B,
  input  logic                  WRITE_ENABLE_B,
  input  logic                  RESERVE_ENABLE,
  input  logic [ADDR_WIDTH-1:0] RESERVE_REG,
  output logic [ADDR_WIDTH:0]   BUSY_COUNT
);

  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [ADDR_WIDTH:0]   busy_count_q;
  logic [ADDR_WIDTH:0]   busy_count_next;

  logic we_a_eff;
  logic we_b_eff;
  logic we_b_commit;
  logic rsv_eff;

  // With a hardwired zero register, anything aimed at index 0 is discarded up front,
  // so neither the array, the scoreboard nor the bypass path ever sees it.
  assign we_a_eff    = WRITE_ENABLE_A && !(ZERO_EN && (WRITE_REG_A == '0));
  assign we_b_eff    = WRITE_ENABLE_B && !(ZERO_EN && (WRITE_REG_B == '0));
  assign rsv_eff     = RESERVE_ENABLE && !(ZERO_EN && (RESERVE_REG == '0));
  assign we_b_commit = we_b_eff && !(we_a_eff && (WRITE_REG_B == WRITE_REG_A));

  always_ff @(posedge CPU_CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we_b_commit) begin
        regs[WRITE_REG_B] <= WRITE_DATA_B;
      end
      if (we_a_eff) begin
        regs[WRITE_REG_A] <= WRITE_DATA_A;
      end
    end
  end

  // A reserve in the same cycle as a release belongs to a newer producer, so set beats clear.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsv_eff && (RESERVE_REG == ADDR_WIDTH'(i))) begin
        busy_next[i] = 1'b1;
      end else if ((we_a_eff && (WRITE_REG_A == ADDR_WIDTH'(i))) ||
                   (we_b_eff && (WRITE_REG_B == ADDR_WIDTH'(i)))) begin
        busy_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_next = busy_count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge CPU_CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      busy         <= '0;
      busy_count_q <= '0;
    end else begin
      busy         <= busy_next;
      busy_count_q <= busy_count_next;
    end
  end

  assign BUSY_COUNT = busy_count_q;

  // Returns {data, busy}; bypass forwards the write data and the release, never a reserve.
  function automatic logic [DATA_WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] d;
    logic                  b;
    d = regs[addr];
    b = busy[addr];
    if (BYPASS_EN) begin
      if (we_a_eff && (WRITE_REG_A == addr)) begin
        d = WRITE_DATA_A;
        b = 1'b0;
      end else if (we_b_eff && (WRITE_REG_B == addr)) begin
        d = WRITE_DATA_B;
        b = 1'b0;
      end
    end
    if (CLEAR || (ZERO_EN && (addr == '0))) begin
      d = '0;
      b = 1'b0;
    end
    return {d, b};
  endfunction

  assign {READ_DATA_1, BUSY_1} = read_port(READ_REG_1);
  assign {READ_DATA_2, BUSY_2} = read_port(READ_REG_2);

endmodule

// File: tb/tb_register_file_dual_write.sv
// Directed bench for register_file_dual_write: default config plus ZERO_REG=1 and
// BYPASS=0 instances sharing the same stimulus.
module tb_register_file_dual_write;

  logic        CPU_CLOCK = 1'b0;
  logic        CLEAR;
  logic [3:0]  READ_REG_1, READ_REG_2, WRITE_REG_A, WRITE_REG_B, RESERVE_REG;
  logic [17:0] WRITE_DATA_A, WRITE_DATA_B;
  logic        WRITE_ENABLE_A, WRITE_ENABLE_B, RESERVE_ENABLE;

  logic [17:0] rd1, rd2, rd1_z, rd2_z, rd1_n, rd2_n;
  logic        b1, b2, b1_z, b2_z, b1_n, b2_n;
  logic [4:0]  cnt, cnt_z, cnt_n;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CPU_CLOCK = ~CPU_CLOCK;

  register_file_dual_write dut (
    .CPU_CLOCK(CPU_CLOCK), .CLEAR(CLEAR),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .READ_DATA_1(rd1), .READ_DATA_2(rd2), .BUSY_1(b1), .BUSY_2(b2),
    .WRITE_REG_A(WRITE_REG_A), .WRITE_DATA_A(WRITE_DATA_A), .WRITE_ENABLE_A(WRITE_ENABLE_A),
    .WRITE_REG_B(WRITE_REG_B), .WRITE_DATA_B(WRITE_DATA_B), .WRITE_ENABLE_B(WRITE_ENABLE_B),
    .RESERVE_ENABLE(RESERVE_ENABLE), .RESERVE_REG(RESERVE_REG), .BUSY_COUNT(cnt)
  );

  register_file_dual_write #(.ZERO_REG(1)) dut_z (
    .CPU_CLOCK(CPU_CLOCK), .CLEAR(CLEAR),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .READ_DATA_1(rd1_z), .READ_DATA_2(rd2_z), .BUSY_1(b1_z), .BUSY_2(b2_z),
    .WRITE_REG_A(WRITE_REG_A), .WRITE_DATA_A(WRITE_DATA_A), .WRITE_ENABLE_A(WRITE_ENABLE_A),
    .WRITE_REG_B(WRITE_REG_B), .WRITE_DATA_B(WRITE_DATA_B), .WRITE_ENABLE_B(WRITE_ENABLE_B),
    .RESERVE_ENABLE(RESERVE_ENABLE), .RESERVE_REG(RESERVE_REG), .BUSY_COUNT(cnt_z)
  );

  register_file_dual_write #(.BYPASS(0)) dut_n (
    .CPU_CLOCK(CPU_CLOCK), .CLEAR(CLEAR),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .READ_DATA_1(rd1_n), .READ_DATA_2(rd2_n), .BUSY_1(b1_n), .BUSY_2(b2_n),
    .WRITE_REG_A(WRITE_REG_A), .WRITE_DATA_A(WRITE_DATA_A), .WRITE_ENABLE_A(WRITE_ENABLE_A),
    .WRITE_REG_B(WRITE_REG_B), .WRITE_DATA_B(WRITE_DATA_B), .WRITE_ENABLE_B(WRITE_ENABLE_B),
    .RESERVE_ENABLE(RESERVE_ENABLE), .RESERVE_REG(RESERVE_REG), .BUSY_COUNT(cnt_n)
  );

  typedef struct {
    logic        we_a;
    logic [3:0]  wa;
    logic [17:0] da;
    logic        we_b;
    logic [3:0]  wb;
    logic [17:0] db;
    logic        rsv;
    logic [3:0]  rr;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [17:0] e_d1;
    logic [17:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic we_a, input logic [3:0] wa, input logic [17:0] da,
                       input logic we_b, input logic [3:0] wb, input logic [17:0] db,
                       input logic rsv, input logic [3:0] rr);
    WRITE_ENABLE_A = we_a; WRITE_REG_A = wa; WRITE_DATA_A = da;
    WRITE_ENABLE_B = we_b; WRITE_REG_B = wb; WRITE_DATA_B = db;
    RESERVE_ENABLE = rsv;  RESERVE_REG = rr;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 18'd0, 1'b0, 4'd0, 18'd0, 1'b0, 4'd0);
  endtask

  task automatic tick();
    @(posedge CPU_CLOCK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we_a wa  da        we_b wb  db        rsv rr  r1  r2  e_d1      e_d2      b1 b2 cnt
    vecs[0] = '{1'b0, 0, 18'h0,     1'b0, 0, 18'h0,     1'b0, 0, 3, 4, 18'h0,     18'h0,     0, 0, 0};
    vecs[1] = '{1'b1, 1, 18'h00101, 1'b0, 0, 18'h0,     1'b0, 0, 1, 2, 18'h00101, 18'h0,     0, 0, 0};
    vecs[2] = '{1'b0, 0, 18'h0,     1'b1, 2, 18'h20202, 1'b0, 0, 1, 2, 18'h00101, 18'h20202, 0, 0, 0};
    vecs[3] = '{1'b0, 0, 18'h0,     1'b0, 0, 18'h0,     1'b1, 4, 4, 1, 18'h0,     18'h00101, 0, 0, 1};
    vecs[4] = '{1'b0, 0, 18'h0,     1'b0, 0, 18'h0,     1'b1, 6, 4, 6, 18'h0,     18'h0,     1, 0, 2};
    vecs[5] = '{1'b0, 0, 18'h0,     1'b0, 0, 18'h0,     1'b1, 4, 4, 6, 18'h0,     18'h0,     1, 1, 2};
    vecs[6] = '{1'b1, 4, 18'h3FFFF, 1'b1, 6, 18'h00006, 1'b0, 0, 4, 6, 18'h3FFFF, 18'h00006, 0, 0, 0};
    vecs[7] = '{1'b1, 8, 18'h11111, 1'b0, 0, 18'h0,     1'b0, 0, 4, 6, 18'h3FFFF, 18'h00006, 0, 0, 0};
    vecs[8] = '{1'b0, 0, 18'h0,     1'b0, 0, 18'h0,     1'b0, 0, 8, 8, 18'h11111, 18'h11111, 0, 0, 0};

    CLEAR = 1'b1;
    idle();
    READ_REG_1 = 4'd3;
    READ_REG_2 = 4'd0;
    #12;
    chk("reset_rd1", rd1, 0);
    chk("reset_b1", b1, 0);
    chk("reset_cnt", cnt, 0);
    #1 CLEAR = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we_a, vecs[i].wa, vecs[i].da, vecs[i].we_b, vecs[i].wb, vecs[i].db,
            vecs[i].rsv, vecs[i].rr);
      READ_REG_1 = vecs[i].r1;
      READ_REG_2 = vecs[i].r2;
      #3;
      chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_d1);
      chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_d2);
      chk($sformatf("vec%0d_b1", i), b1, vecs[i].e_b1);
      chk($sformatf("vec%0d_b2", i), b2, vecs[i].e_b2);
      tick();
      chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].e_cnt);
    end

    // A and B collide on reg 5: A wins, forwarded in-cycle
    drive(1'b1, 4'd5, 18'h00011, 1'b1, 4'd5, 18'h3FFFF, 1'b0, 4'd0);
    READ_REG_1 = 4'd5;
    #3 chk("collide_bypass", rd1, 18'h00011);
    tick();
    idle();
    #3 chk("collide_stored", rd1, 18'h00011);
    chk("collide_stored_nb", rd1_n, 18'h00011);

    // reserve 7, then release it through port B
    drive(1'b0, 4'd0, 18'h0, 1'b0, 4'd0, 18'h0, 1'b1, 4'd7);
    READ_REG_1 = 4'd7;
    tick();
    idle();
    #3 chk("rsv7_busy", b1, 1);
    chk("rsv7_cnt", cnt, 1);
    tick();
    drive(1'b0, 4'd0, 18'h0, 1'b1, 4'd7, 18'h12345, 1'b0, 4'd0);
    #3 chk("rel7_busy_fwd", b1, 0);
    chk("rel7_data_fwd", rd1, 18'h12345);
    chk("rel7_nb_busy", b1_n, 1);
    chk("rel7_nb_data", rd1_n, 18'h0);
    tick();
    idle();
    chk("rel7_cnt", cnt, 0);

    // reserve and write reg 9 in the same cycle: data lands, busy stays
    drive(1'b1, 4'd9, 18'h0ABCD, 1'b0, 4'd0, 18'h0, 1'b1, 4'd9);
    READ_REG_1 = 4'd9;
    tick();
    idle();
    #3 chk("rw9_data", rd1, 18'h0ABCD);
    chk("rw9_busy", b1, 1);
    chk("rw9_cnt", cnt, 1);

    // write and reserve reg 0: dropped only in the ZERO_REG instance
    drive(1'b1, 4'd0, 18'h3FFFF, 1'b0, 4'd0, 18'h0, 1'b1, 4'd0);
    READ_REG_1 = 4'd0;
    READ_REG_2 = 4'd0;
    #3 chk("z0_rd1_fwd", rd1_z, 0);
    chk("z0_b1_fwd", b1_z, 0);
    chk("z0_rd2_fwd", rd2_z, 0);
    tick();
    idle();
    #3 chk("z0_rd1", rd1_z, 0);
    chk("z0_b2", b2_z, 0);
    chk("z0_cnt", cnt_z, 1);
    chk("r0_plain_data", rd1, 18'h3FFFF);
    chk("r0_plain_busy", b1, 1);
    chk("r0_plain_cnt", cnt, 2);

    // no bypass: old value in-cycle, new value after the edge
    drive(1'b1, 4'd2, 18'h00AAA, 1'b0, 4'd0, 18'h0, 1'b0, 4'd0);
    READ_REG_2 = 4'd2;
    #3 chk("nb2_old", rd2_n, 18'h20202);
    chk("nb2_busy", b2_n, 0);
    tick();
    idle();
    #3 chk("nb2_new", rd2_n, 18'h00AAA);

    for (int r = 0; r < 16; r++) begin
      drive(1'b0, 4'd0, 18'h0, 1'b0, 4'd0, 18'h0, 1'b1, 4'(r));
      tick();
    end
    idle();
    chk("all_rsv_cnt_nb", cnt_n, 16);
    chk("all_rsv_cnt", cnt, 16);
    chk("all_rsv_cnt_z", cnt_z, 15);

    // CLEAR mid-cycle with reg 3 holding data and busy
    drive(1'b1, 4'd3, 18'h2ABCD, 1'b0, 4'd0, 18'h0, 1'b1, 4'd3);
    READ_REG_1 = 4'd3;
    tick();
    idle();
    #2 chk("pre_clr_data", rd1, 18'h2ABCD);
    chk("pre_clr_busy", b1, 1);
    CLEAR = 1'b1;
    #1 chk("clr_data", rd1, 0);
    chk("clr_busy", b1, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_cnt_nb", cnt_n, 0);
    drive(1'b1, 4'd3, 18'h15555, 1'b0, 4'd0, 18'h0, 1'b1, 4'd3);
    #1 chk("clr_no_fwd", rd1, 0);
    tick();
    chk("clr_edge_cnt", cnt, 0);
    idle();
    #1 CLEAR = 1'b0;
    #1 chk("post_clr_data", rd1, 0);
    chk("post_clr_busy", b1, 0);
    tick();
    chk("post_clr_cnt", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
